// File: rtl/alu_regfile_pkg.sv
// Shared opcode and FSM state encodings for the register-file ALU core.
package alu_regfile_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MUL  = 3'b010,
        OP_DIV  = 3'b011,
        OP_LOAD = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_regfile_core_seq_divider.sv
// Unsigned restoring divider producing one quotient bit per cycle, MSB first.
module seq_divider
    import alu_regfile_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] den_q;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   trial;
    logic             fits;

    // quotient/remainder present the result of the step taken on the next edge,
    // so the parent can write back on the same edge as the final iteration.
    always_comb begin
        trial     = {rem_q, quo_q[WIDTH-1]};
        fits      = (trial >= {1'b0, den_q});
        quotient  = {quo_q[WIDTH-2:0], fits};
        remainder = fits ? (trial[WIDTH-1:0] - den_q) : trial[WIDTH-1:0];
    end

    assign done = busy && (count == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            count <= '0;
            quo_q <= '0;
            rem_q <= '0;
            den_q <= '0;
        end else if (start && !busy) begin
            busy  <= 1'b1;
            count <= '0;
            quo_q <= dividend;
            rem_q <= '0;
            den_q <= divisor;
        end else if (busy) begin
            quo_q <= quotient;
            rem_q <= remainder;
            count <= count + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_regfile_core.sv
// Sequential ALU with an internal register file, one instruction in flight at a time.
module alu_regfile_core
    import alu_regfile_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 16,
    localparam int AW = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] op,
    input  logic [AW-1:0]   rd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic [WIDTH-1:0] imm,
    input  logic            ci,
    output logic            done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] rem,
    output logic            flag_c,
    output logic            flag_v,
    output logic            flag_dz,
    output logic            flag_err,
    input  logic [AW-1:0]   dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] EXEC   = ST_EXEC;
    localparam logic [1:0] DIVIDE = ST_DIV;

    logic [WIDTH-1:0]   regs [NREGS];
    logic [1:0]         state;
    logic [OP_W-1:0]    op_q;
    logic [AW-1:0]      rd_q;
    logic               ci_q;
    logic [WIDTH-1:0]   imm_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;

    logic               accept;
    logic               div_start;
    logic               div_busy;
    logic               div_done;
    logic [WIDTH-1:0]   div_quo;
    logic [WIDTH-1:0]   div_rem;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   exec_result;
    logic [WIDTH-1:0]   exec_rem;
    logic               exec_c;
    logic               exec_v;
    logic               exec_dz;
    logic               exec_err;
    logic               exec_we;

    assign in_ready  = (state == IDLE) && !div_busy;
    assign accept    = in_valid && in_ready;
    assign div_start = accept && (op == OP_DIV) && (regs[rs2] != '0);
    assign dbg_data  = regs[dbg_addr];

    seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (regs[rs1]),
        .divisor   (regs[rs2]),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Single-cycle ops work on operands captured at accept; a DIV that reaches
    // EXEC is always a divide-by-zero, since nonzero divisors go to DIVIDE.
    always_comb begin
        sum         = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, ci_q};
        diff        = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, ci_q};
        prod        = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        exec_result = '0;
        exec_rem    = '0;
        exec_c      = 1'b0;
        exec_v      = 1'b0;
        exec_dz     = 1'b0;
        exec_err    = 1'b0;
        exec_we     = 1'b0;
        case (op_q)
            OP_ADD: begin
                exec_result = sum[WIDTH-1:0];
                exec_c      = sum[WIDTH];
                exec_we     = 1'b1;
            end
            OP_SUB: begin
                exec_result = diff[WIDTH-1:0];
                exec_c      = diff[WIDTH];
                exec_we     = 1'b1;
            end
            OP_MUL: begin
                exec_result = prod[WIDTH-1:0];
                exec_v      = |prod[2*WIDTH-1:WIDTH];
                exec_we     = 1'b1;
            end
            OP_DIV: begin
                exec_result = '1;
                exec_rem    = a_q;
                exec_dz     = 1'b1;
                exec_we     = 1'b1;
            end
            OP_LOAD: begin
                exec_result = imm_q;
                exec_we     = 1'b1;
            end
            default: begin
                exec_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            ci_q     <= 1'b0;
            imm_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            done     <= 1'b0;
            result   <= '0;
            rem      <= '0;
            flag_c   <= 1'b0;
            flag_v   <= 1'b0;
            flag_dz  <= 1'b0;
            flag_err <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q  <= op;
                        rd_q  <= rd;
                        ci_q  <= ci;
                        imm_q <= imm;
                        a_q   <= regs[rs1];
                        b_q   <= regs[rs2];
                        state <= div_start ? DIVIDE : EXEC;
                    end
                end
                EXEC: begin
                    if (exec_we) begin
                        regs[rd_q] <= exec_result;
                    end
                    result   <= exec_result;
                    rem      <= exec_rem;
                    flag_c   <= exec_c;
                    flag_v   <= exec_v;
                    flag_dz  <= exec_dz;
                    flag_err <= exec_err;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                DIVIDE: begin
                    if (div_done) begin
                        regs[rd_q] <= div_quo;
                        result     <= div_quo;
                        rem        <= div_rem;
                        flag_c     <= 1'b0;
                        flag_v     <= 1'b0;
                        flag_dz    <= 1'b0;
                        flag_err   <= 1'b0;
                        done       <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_regfile_core.sv
// Self-checking bench: directed vector table, hand sequences and a randomized run against a reference model.
module tb_alu_regfile_core;

    localparam int W  = 16;
    localparam int N  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic [AW-1:0] rd, rs1, rs2;
    logic [W-1:0]  imm;
    logic          ci;
    logic          done;
    logic [W-1:0]  result, rem;
    logic          flag_c, flag_v, flag_dz, flag_err;
    logic [AW-1:0] dbg_addr;
    logic [W-1:0]  dbg_data;

    always #5 clk = ~clk;

    alu_regfile_core #(.WIDTH(W), .NREGS(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .imm      (imm),
        .ci       (ci),
        .done     (done),
        .result   (result),
        .rem      (rem),
        .flag_c   (flag_c),
        .flag_v   (flag_v),
        .flag_dz  (flag_dz),
        .flag_err (flag_err),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] rem;
        logic         c, v, dz, err, we;
        int           lat;
    } exp_t;

    typedef struct {
        logic [2:0]    op;
        logic [AW-1:0] rd, rs1, rs2;
        logic [W-1:0]  imm;
        logic          ci;
        logic [W-1:0]  e_res, e_rem;
        logic          e_c, e_v, e_dz, e_err;
        int            e_lat;
    } vec_t;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] model_regs [N];
    vec_t         vecs [$];

    int           got_lat;
    logic         timed_out;
    logic         ready_low;
    logic         ready_at_done;
    logic [W-1:0] got_res, got_rem;
    logic         got_c, got_v, got_dz, got_err;
    time          acc_time;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Behavioural reference computed with plain integer arithmetic.
    function automatic exp_t ref_model(input logic [2:0] o, input longint unsigned a, input longint unsigned b,
                                       input logic c, input longint unsigned im);
        longint unsigned md, t;
        exp_t e;
        md    = 64'd1 << W;
        e.res = '0; e.rem = '0; e.c = 0; e.v = 0; e.dz = 0; e.err = 0; e.we = 1; e.lat = 1;
        case (o)
            3'd0: begin t = a + b + c; e.res = W'(t % md); e.c = (t >= md); end
            3'd1: begin e.res = W'((a + 2 * md - b - c) % md); e.c = (a < b + c); end
            3'd2: begin t = a * b; e.res = W'(t % md); e.v = (t >= md); end
            3'd3: begin
                if (b == 0) begin
                    e.res = W'(md - 1); e.rem = W'(a); e.dz = 1;
                end else begin
                    e.res = W'(a / b); e.rem = W'(a % b); e.lat = W;
                end
            end
            3'd4: e.res = W'(im);
            default: begin e.err = 1; e.we = 0; end
        endcase
        return e;
    endfunction

    function automatic vec_t mk(input int o, input int d, input int s1, input int s2, input int im, input int c,
                                input int r, input int rm, input int ec, input int ev, input int edz,
                                input int eerr, input int lat);
        vec_t v;
        v.op = 3'(o); v.rd = AW'(d); v.rs1 = AW'(s1); v.rs2 = AW'(s2); v.imm = W'(im); v.ci = c[0];
        v.e_res = W'(r); v.e_rem = W'(rm); v.e_c = ec[0]; v.e_v = ev[0]; v.e_dz = edz[0];
        v.e_err = eerr[0]; v.e_lat = lat;
        return v;
    endfunction

    // Called at a falling edge; returns at the falling edge where done is seen.
    task automatic applyStimulus(input logic [2:0] o, input logic [AW-1:0] d, input logic [AW-1:0] s1,
                                 input logic [AW-1:0] s2, input logic [W-1:0] im, input logic c);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        op = o; rd = d; rs1 = s1; rs2 = s2; imm = im; ci = c;
        in_valid = 1'b1;
        @(posedge clk);
        acc_time = $time;
        @(negedge clk);
        in_valid  = 1'b0;
        got_lat   = 0;
        ready_low = 1'b1;
        while (!done && got_lat < 100) begin
            if (in_ready) ready_low = 1'b0;
            @(negedge clk);
            got_lat++;
        end
        timed_out     = !done;
        ready_at_done = in_ready;
        got_res = result; got_rem = rem;
        got_c = flag_c; got_v = flag_v; got_dz = flag_dz; got_err = flag_err;
    endtask

    task automatic run_and_check(input string tag, input logic [2:0] o, input logic [AW-1:0] d,
                                 input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                                 input logic [W-1:0] im, input logic c, input exp_t e);
        applyStimulus(o, d, s1, s2, im, c);
        checkOutput({tag, ".timeout"}, 64'(timed_out), 64'd0);
        checkOutput({tag, ".result"}, 64'(got_res), 64'(e.res));
        checkOutput({tag, ".rem"}, 64'(got_rem), 64'(e.rem));
        checkOutput({tag, ".flags_cvze"}, 64'({got_c, got_v, got_dz, got_err}), 64'({e.c, e.v, e.dz, e.err}));
        checkOutput({tag, ".latency"}, 64'(got_lat), 64'(e.lat));
        checkOutput({tag, ".ready_busy_low"}, 64'(ready_low), 64'd1);
        checkOutput({tag, ".ready_at_done"}, 64'(ready_at_done), 64'd1);
        if (e.we) model_regs[d] = e.res;
        dbg_addr = d;
        #1;
        checkOutput({tag, ".reg_rd"}, 64'(dbg_data), 64'(model_regs[d]));
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < N; i++) begin
            dbg_addr = AW'(i);
            #1;
            checkOutput($sformatf("%s.reg%0d", tag, i), 64'(dbg_data), 64'(model_regs[i]));
        end
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        time  t_first;
        int   seen_done;
        int   sel;
        logic [2:0] ro;
        logic [AW-1:0] rdd, r1, r2;
        logic [W-1:0]  rim;
        logic          rc;

        rst = 1'b1; in_valid = 1'b0; op = '0; rd = '0; rs1 = '0; rs2 = '0;
        imm = '0; ci = 1'b0; dbg_addr = '0;
        for (int i = 0; i < N; i++) model_regs[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        checkOutput("reset.in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset.done", 64'(done), 64'd0);
        checkOutput("reset.result", 64'(result), 64'd0);
        checkOutput("reset.rem", 64'(rem), 64'd0);
        checkOutput("reset.flags", 64'({flag_c, flag_v, flag_dz, flag_err}), 64'd0);
        check_all_regs("reset");

        //      op  rd rs1 rs2 imm     ci  res     rem     c  v  dz err lat
        vecs.push_back(mk(4, 1, 0, 0, 16'hFFFF, 0, 16'hFFFF, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4, 2, 0, 0, 16'h0001, 0, 16'h0001, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 3, 1, 2, 0,        0, 16'h0000, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(4, 5, 0, 0, 3,        0, 3,        0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4, 6, 0, 0, 5,        0, 5,        0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 7, 5, 6, 0,        1, 16'hFFFD, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(4, 0, 0, 0, 16'h1234, 0, 16'h1234, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4, 8, 0, 0, 16'h0100, 0, 16'h0100, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(2, 9, 8, 8, 0,        0, 16'h0000, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(4, 10, 0, 0, 16'h00FF, 0, 16'h00FF, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4, 12, 0, 0, 2,       0, 2,        0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(2, 11, 10, 12, 0,     0, 16'h01FE, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4, 13, 0, 0, 100,     0, 100,      0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4, 14, 0, 0, 7,       0, 7,        0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(3, 4, 13, 14, 0,      0, 14,       2, 0, 0, 0, 0, W));
        vecs.push_back(mk(4, 15, 0, 0, 16'h00AB, 0, 16'h00AB, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(3, 9, 15, 3, 0,       0, 16'hFFFF, 16'h00AB, 0, 0, 1, 0, 1));
        vecs.push_back(mk(7, 5, 1, 2, 16'h5555, 1, 0,        0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 5, 5, 5, 0,        1, 7,        0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 6, 3, 3, 0,        0, 0,        0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 6, 3, 2, 0,        0, 16'hFFFF, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 7, 1, 3, 0,        1, 16'h0000, 0, 1, 0, 0, 0, 1));

        foreach (vecs[i]) begin
            e.res = vecs[i].e_res; e.rem = vecs[i].e_rem; e.c = vecs[i].e_c; e.v = vecs[i].e_v;
            e.dz = vecs[i].e_dz; e.err = vecs[i].e_err; e.we = !vecs[i].e_err; e.lat = vecs[i].e_lat;
            run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                          vecs[i].imm, vecs[i].ci, e);
        end
        check_all_regs("after_table");

        // Back-to-back ADDs: the second accept lands two cycles after the first.
        e = ref_model(3'd0, model_regs[1], model_regs[2], 1'b0, 0);
        run_and_check("b2b0", 3'd0, 4'd3, 4'd1, 4'd2, '0, 1'b0, e);
        t_first = acc_time;
        e = ref_model(3'd0, model_regs[3], model_regs[13], 1'b1, 0);
        run_and_check("b2b1", 3'd0, 4'd3, 4'd3, 4'd13, '0, 1'b1, e);
        checkOutput("b2b.accept_spacing", 64'(acc_time - t_first), 64'd20);

        // Reset during a divide: no completion, register file cleared.
        @(negedge clk);
        op = 3'd3; rd = 4'd4; rs1 = 4'd1; rs2 = 4'd14; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) model_regs[i] = '0;
        checkOutput("abort.in_ready", 64'(in_ready), 64'd1);
        seen_done = 0;
        for (int i = 0; i < 24; i++) begin
            if (done) seen_done++;
            @(negedge clk);
        end
        checkOutput("abort.no_done", 64'(seen_done), 64'd0);
        checkOutput("abort.result", 64'(result), 64'd0);
        check_all_regs("abort");

        // Randomized instructions against the reference model.
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 11);
            case (sel)
                0, 1:    ro = 3'd0;
                2, 3:    ro = 3'd1;
                4, 5:    ro = 3'd2;
                6, 7:    ro = 3'd3;
                8, 9, 10: ro = 3'd4;
                default: ro = 3'($urandom_range(5, 7));
            endcase
            rdd = AW'($urandom_range(0, N - 1));
            r1  = AW'($urandom_range(0, N - 1));
            r2  = AW'($urandom_range(0, N - 1));
            rc  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       rim = '0;
                1:       rim = '1;
                2:       rim = W'($urandom_range(0, 15));
                default: rim = W'($urandom);
            endcase
            e = ref_model(ro, model_regs[r1], model_regs[r2], rc, rim);
            run_and_check($sformatf("rnd%0d", n), ro, rdd, r1, r2, rim, rc, e);
        end
        check_all_regs("after_random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
